seq_multiplier: RTL and testbench

//   Iterative 32x32 -> 64-bit shift-add multiplier for the CPU's MULT/MULTU instructions.
//   It is the multiplicative counterpart of the sequential divider and shares its

---
 rtl/seq_multiplier.sv | 107 ++++++++++
 tb/tb_seq_multiplier.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative 32x32 -> 64-bit shift-add multiplier for MULT/MULTU.
//   Operands are reduced to magnitudes on the start edge, multiplied unsigned over
//   WIDTH iterations, and the product is negated at the end if the operand signs differ.
//   All state changes on the falling edge of clock; reset is asynchronous, active-high.
// Ports:
//   clock  in   falling-edge clock
//   reset  in   asynchronous active-high reset
//   a, b   in   multiplicand / multiplier (WIDTH bits)
//   start  in   request a multiply; sampled only while idle
//   sign   in   1 = signed (two's complement), 0 = unsigned
//   hi, lo out  upper / lower halves of the last product (registered)
//   busy   out  operation in progress
//   done   out  one-cycle pulse when hi/lo update
module seq_multiplier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic             sign,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  state_t             state_q;
  logic [WIDTH:0]     acc_q;    // extra bit keeps the carry of acc + mcand
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplr_q;   // shifts out multiplier bits, shifts in low product bits
  logic               neg_q;
  logic [CNT_W-1:0]   count_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_shift;
  logic [WIDTH-1:0]   mplr_shift;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      prod_fix;
  logic               last_iter;

  always_comb begin
    // Most negative value maps to itself, which is its correct unsigned magnitude.
    a_mag      = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag      = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    sum        = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    acc_shift  = {1'b0, sum[WIDTH:1]};
    mplr_shift = {sum[0], mplr_q[WIDTH-1:1]};
    // Product as it stands after the final iteration's shift.
    prod       = {acc_shift[WIDTH-1:0], mplr_shift};
    // Two's complement negate; zero stays zero.
    prod_fix   = neg_q ? (~prod + PW'(1)) : prod;
    last_iter  = (count_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q <= a_mag;
            mplr_q  <= b_mag;
            neg_q   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q   <= '0;
            count_q <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_shift;
          mplr_q  <= mplr_shift;
          count_q <= count_q + CNT_W'(1);
          if (last_iter) begin
            hi      <= prod_fix[PW-1:WIDTH];
            lo      <= prod_fix[WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: a reference product is queued whenever a
// start is accepted and compared against hi/lo when done pulses.
module tb_seq_multiplier;

  logic        clock;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        sign;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          n_checks;
  int          n_errors;
  logic [63:0] sb[$];
  logic [63:0] last_res;

  seq_multiplier #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .a    (a),
    .b    (b),
    .start(start),
    .sign (sign),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [63:0] sx;
    logic [63:0] sy;
    sx = s ? {{32{x[31]}}, x} : {32'b0, x};
    sy = s ? {{32{y[31]}}, y} : {32'b0, y};
    return sx * sy;
  endfunction

  // Scoreboard consumer; outputs sampled on the rising edge, away from the active edge.
  initial begin
    logic        done_prev;
    logic [63:0] exp;
    done_prev = 1'b0;
    forever begin
      @(posedge clock);
      if (done_prev) check("done_pulse", {63'b0, done}, 64'd0);
      if (done) begin
        check("sb_nonempty", {63'b0, sb.size() != 0}, 64'd1);
        check("busy_at_done", {63'b0, busy}, 64'd0);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("product", {hi, lo}, exp);
          last_res = exp;
        end
      end
      done_prev = done;
    end
  end

  // One operation; optionally pulses start and scrambles inputs while busy.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input bit disturb, output logic [63:0] res);
    int cycles;
    bit got;
    bit busy_ok;
    @(posedge clock);
    a = ta;
    b = tb_v;
    sign = ts;
    start = 1'b1;
    sb.push_back(model(ta, tb_v, ts));
    cycles = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && cycles < 40) begin
      @(posedge clock);
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        check("hold_prev", {hi, lo}, last_res);
      end
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (disturb && !got) begin
        a = $urandom;
        b = $urandom;
        sign = ~sign;
        start = (cycles == 11);
      end
    end
    start = 1'b0;
    check("completed", {63'b0, got}, 64'd1);
    check("latency", 64'(cycles), 64'd33);
    check("busy_held", {63'b0, busy_ok}, 64'd1);
    res = {hi, lo};
  endtask

  initial begin
    logic [63:0] res;
    int cycles;
    bit got;
    n_checks = 0;
    n_errors = 0;
    last_res = '0;
    reset = 1'b1;
    start = 1'b0;
    sign = 1'b0;
    a = '0;
    b = '0;
    #2;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clock);
    @(posedge clock);
    reset = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 1'b0, res);
    check("t1_7x6", res, 64'h0000_0000_0000_002A);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, res);
    check("t2_m3x5", res, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, res);
    check("t3_umax", res, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, res);
    check("t3_sm1", res, 64'h0000_0000_0000_0001);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, res);
    check("t4_minsq", res, 64'h4000_0000_0000_0000);
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, res);
    check("t4_minx1", res, 64'hFFFF_FFFF_8000_0000);
    run_op(32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, res);
    check("zero_neg", res, 64'd0);

    // Start and input changes while busy must be ignored.
    run_op(32'd5, 32'd5, 1'b0, 1'b1, res);
    check("t5_ignore", res, 64'd25);
    repeat (3) @(posedge clock);
    check("t5_no_restart", {63'b0, busy}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, res);
    end

    // Back-to-back with start held high: second op begins on the edge after done.
    @(posedge clock);
    a = 32'd3;
    b = 32'd4;
    sign = 1'b0;
    start = 1'b1;
    sb.push_back(model(32'd3, 32'd4, 1'b0));
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 40) begin
      @(posedge clock);
      cycles++;
      got = done;
    end
    check("b2b_first", {63'b0, got}, 64'd1);
    a = 32'hFFFF_FFF0;
    b = 32'h0000_0010;
    sign = 1'b1;
    sb.push_back(model(32'hFFFF_FFF0, 32'h0000_0010, 1'b1));
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 40) begin
      @(posedge clock);
      cycles++;
      if (cycles == 1) check("b2b_busy", {63'b0, busy}, 64'd1);
      got = done;
    end
    start = 1'b0;
    check("b2b_second", {63'b0, got}, 64'd1);
    check("b2b_latency", 64'(cycles), 64'd33);
    check("b2b_value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FF00);

    // Asynchronous reset mid-operation.
    @(posedge clock);
    a = 32'd1000;
    b = 32'd1000;
    sign = 1'b0;
    start = 1'b1;
    repeat (13) begin
      @(posedge clock);
      start = 1'b0;
    end
    check("abort_busy_before", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    sb.delete();
    last_res = '0;
    @(posedge clock);
    reset = 1'b0;
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, res);
    check("t6_after_reset", res, 64'h0000_0001_0000_0000);

    repeat (3) @(posedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
